// File: rtl/bsctrl_pkg.sv
// bsctrl_pkg: shared types and constants for the bitstream window controller.
//   state_e        : sequencer states (IDLE / FETCH / LOAD)
//   NBITS_MAX      : largest legal Show/Get width
//   REFILL_THRESH  : refill starts while incnt is at or below this
//   WIN_W          : width of the bit window
//   nbits_legal()  : 1 when a request width lies in 1..NBITS_MAX
package bsctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD
  } state_e;

  localparam int unsigned NBITS_MAX     = 24;
  localparam int unsigned REFILL_THRESH = 24;
  localparam int unsigned WIN_W         = 32;

  function automatic logic nbits_legal(input logic [4:0] n);
    return (n != 5'd0) && (n <= 5'(NBITS_MAX));
  endfunction

endpackage

// File: rtl/bitstream_ctrl_if.sv
// bitstream_ctrl_if: requester and byte-buffer signals of bitstream_ctrl.
//   req/req_nbits/req_flush  requester -> ctrl (5-bit width per requester)
//   gnt/rd_data/err          ctrl -> requester, one-cycle pulses
//   mem_rd/mem_addr          ctrl -> byte buffer, read strobe and address
//   mem_data                 byte buffer -> ctrl, valid the cycle after mem_rd
//   bytes_avail/byte_taken   producer fill level and per-byte consume pulse
// modport slave : the controller; modport master : requesters + buffer side.
interface bitstream_ctrl_if
  import bsctrl_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 11
);
  logic [NREQ-1:0]   req;
  logic [NREQ*5-1:0] req_nbits;
  logic [NREQ-1:0]   req_flush;
  logic [NREQ-1:0]   gnt;
  logic [WIN_W-1:0]  rd_data;
  logic              err;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [ADDR_W:0]   bytes_avail;
  logic              byte_taken;

  modport slave (
    input  req, req_nbits, req_flush, mem_data, bytes_avail,
    output gnt, rd_data, err, mem_rd, mem_addr, byte_taken
  );

  modport master (
    output req, req_nbits, req_flush, mem_data, bytes_avail,
    input  gnt, rd_data, err, mem_rd, mem_addr, byte_taken
  );
endinterface

// File: rtl/bsctrl_rr_arb.sv
// bsctrl_rr_arb: NREQ-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset (pointer -> requester 0)
//   elig_i   : eligibility mask; all-zero means no arbitration this cycle
//   gnt_o    : one-hot combinational winner
// The pointer moves to winner+1 only in cycles that produce a winner.
module bsctrl_rr_arb
  import bsctrl_pkg::*;
#(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] elig_i,
  output logic [NREQ-1:0] gnt_o
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int unsigned   idx;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(ptr_q) + off) % NREQ;
      if (!found && elig_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = PW'((idx + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/bitstream_ctrl.sv
// bitstream_ctrl: owns the 32-bit bit window and its valid count (incnt),
// refills it one byte at a time from the byte buffer and serves Show_Bits /
// Get_Bits requests from NREQ requesters under round-robin arbitration.
//   clk, rst    : single clock, synchronous active-high reset
//   bus (slave) : requester handshake + byte buffer port (bitstream_ctrl_if)
//   align_req / align_done : only with BSCTRL_ALIGN_EN defined; flushes
//                 incnt mod 8 bits to reach a byte boundary.
module bitstream_ctrl
  import bsctrl_pkg::*;
#(
  parameter int unsigned NREQ      = 3,
  parameter int unsigned BUF_BYTES = 2048,
  parameter int unsigned ADDR_W    = 11
) (
  input  logic clk,
  input  logic rst,
`ifdef BSCTRL_ALIGN_EN
  input  logic align_req,
  output logic align_done,
`endif
  bitstream_ctrl_if.slave bus
);
  state_e            state_q, state_d;
  logic [WIN_W-1:0]  window_q, window_d;
  logic [5:0]        incnt_q, incnt_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [WIN_W-1:0]  rd_data_q, rd_data_d;
  logic              err_q, err_d;
`ifdef BSCTRL_ALIGN_EN
  logic              align_done_q, align_done_d;
`endif

  logic            refill_go;
  logic            arb_en;
  logic [NREQ-1:0] elig, arb_gnt;
  logic [4:0]      win_n;
  logic            win_flush;

  assign refill_go = (incnt_q <= 6'(REFILL_THRESH)) && (bus.bytes_avail != '0);

`ifdef BSCTRL_ALIGN_EN
  assign arb_en = (state_q == ST_IDLE) && !align_req && !refill_go;
`else
  assign arb_en = (state_q == ST_IDLE) && !refill_go;
`endif

  // A requester whose grant is visible this cycle still holds req; it is
  // masked so the same request is not served twice.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = arb_en && bus.req[i] && !gnt_q[i] &&
                (!nbits_legal(bus.req_nbits[i*5 +: 5]) ||
                 ({1'b0, bus.req_nbits[i*5 +: 5]} <= incnt_q));
    end
  end

  bsctrl_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .elig_i (elig),
    .gnt_o  (arb_gnt)
  );

  always_comb begin
    win_n     = '0;
    win_flush = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        win_n     = bus.req_nbits[i*5 +: 5];
        win_flush = bus.req_flush[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    window_d  = window_q;
    incnt_d   = incnt_q;
    rd_ptr_d  = rd_ptr_q;
    gnt_d     = '0;
    rd_data_d = '0;
    err_d     = 1'b0;
`ifdef BSCTRL_ALIGN_EN
    align_done_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef BSCTRL_ALIGN_EN
        if (align_req) begin
          window_d     = window_q << incnt_q[2:0];
          incnt_d      = incnt_q - {3'b000, incnt_q[2:0]};
          align_done_d = 1'b1;
        end else
`endif
        if (refill_go) begin
          state_d = ST_FETCH;
        end else if (|arb_gnt) begin
          gnt_d = arb_gnt;
          if (!nbits_legal(win_n)) begin
            err_d = 1'b1;
          end else begin
            rd_data_d = window_q >> (6'd32 - {1'b0, win_n});
            if (win_flush) begin
              window_d = window_q << win_n;
              incnt_d  = incnt_q - {1'b0, win_n};
            end
          end
        end
      end
      ST_FETCH: begin
        rd_ptr_d = (rd_ptr_q == ADDR_W'(BUF_BYTES - 1)) ? '0 : rd_ptr_q + ADDR_W'(1);
        state_d  = ST_LOAD;
      end
      ST_LOAD: begin
        // incnt <= 24 here, so the new byte lands just below the valid bits.
        window_d = window_q | ({24'd0, bus.mem_data} << (6'(REFILL_THRESH) - incnt_q));
        incnt_d  = incnt_q + 6'd8;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      window_q  <= '0;
      incnt_q   <= '0;
      rd_ptr_q  <= '0;
      gnt_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
`ifdef BSCTRL_ALIGN_EN
      align_done_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      window_q  <= window_d;
      incnt_q   <= incnt_d;
      rd_ptr_q  <= rd_ptr_d;
      gnt_q     <= gnt_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
`ifdef BSCTRL_ALIGN_EN
      align_done_q <= align_done_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.err        = err_q;
  assign bus.mem_rd     = (state_q == ST_FETCH);
  assign bus.byte_taken = (state_q == ST_FETCH);
  assign bus.mem_addr   = rd_ptr_q;
`ifdef BSCTRL_ALIGN_EN
  assign align_done     = align_done_q;
`endif
endmodule

// File: doc/bitstream_ctrl.md
# bitstream_ctrl

Sequencer and arbiter for the MPEG bitstream window: owns the 32-bit bit buffer and its valid-bit count (incnt), refills it byte-by-byte from the input byte buffer, and serves Show_Bits/Get_Bits requests from several decoder requesters (header parser, VLC decoder, motion-vector decoder) under round-robin arbitration. It sits between the byte buffer memory and all bit consumers.

## Interface
- NREQ, 3: number of requesters.
- BUF_BYTES, 2048: byte buffer depth (power of two).
- ADDR_W, 11: log2(BUF_BYTES).

- clk  in  1  clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request per requester; held until granted.
- req_nbits  in  NREQ*5  bits wanted per requester, legal 1..24.
- req_flush  in  NREQ  1 = Get_Bits (consume), 0 = Show_Bits (peek).
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- rd_data  out  32  right-aligned result, valid with gnt.
- err  out  1  pulses with gnt if nbits illegal.
- mem_rd  out  1  byte read strobe.
- mem_addr  out  ADDR_W  byte address.
- mem_data  in  8  read data, valid one cycle after mem_rd.
- bytes_avail  in  ADDR_W+1  unread bytes in buffer (producer-owned).
- byte_taken  out  1  pulse per byte fetched; producer decrements bytes_avail.

## Operation
- Reset: window=0, incnt=0, rd_ptr=0, state IDLE; gnt, err, mem_rd, byte_taken, rd_data all 0.
- States: IDLE, FETCH, LOAD.
- IDLE: if incnt<=24 and bytes_avail>0 -> FETCH (refill has priority). Else, among requesters with req=1 and (illegal nbits or nbits<=incnt), round-robin winner granted this cycle; stay IDLE.
- FETCH: mem_rd=1, mem_addr=rd_ptr, byte_taken=1; rd_ptr+=1 mod BUF_BYTES -> LOAD.
- LOAD: window |= mem_data << (24-incnt); incnt+=8 -> IDLE.
- Serve (legal n): rd_data = window >> (32-n); if flush, window <<= n, incnt -= n. Peek leaves window/incnt unchanged.
- Illegal n (0 or >24): gnt and err pulse, rd_data=0, no state change.
- Starvation (bytes_avail=0): requests with n<=incnt still served; others wait, req held.
- Round-robin pointer advances to winner+1 only on grant; after reset requester 0 highest.
- incnt never exceeds 32; window bits below incnt are always 0.

## Timing
- Refill: 2 cycles per byte (FETCH, LOAD) plus 1 IDLE decision cycle; from empty, window reaches 32 bits after 4 bytes (12 cycles).
- Grant: gnt, rd_data, err registered, asserted the cycle after IDLE selects; at most one grant per IDLE cycle, never during FETCH/LOAD.
- Consuming request granted with incnt≥25 leaves incnt≥1; next IDLE starts refill.
- Requester must drop or change req the cycle after gnt; a still-high req is a new request.
- rst mid-FETCH/LOAD: dropped fetch is lost; rd_ptr returns to 0 (producer resets too).

## Configuration
- BSCTRL_ALIGN_EN defined: adds ports align_req (in, 1) and align_done (out, 1). In IDLE align_req beats refill and requesters: flush incnt mod 8 bits (next_start_code byte-alignment), align_done pulses next cycle; 0-bit flush still pulses.
- Undefined: ports absent, no alignment logic.

## Structure
- bsctrl_pkg: state enum, NBITS_MAX=24, REFILL_THRESH=24, WIN_W=32.
- One sub-module: bsctrl_rr_arb (NREQ-way round-robin, eligibility mask in, one-hot grant out, pointer update on grant).

## Test plan
- Reset, bytes_avail=4, bytes 0x12,0x34,0x56,0x78 -> four fetches at addr 0..3, incnt=32, no grant meanwhile.
- Req0 Get 8 -> rd_data=0x12, incnt 24, refill fetch at addr 4 next.
- Req1 Show 12 then Get 12 on window 0x12345678 -> both 0x123, incnt changes only after second.
- All three req Get 4 continuously -> grants 0,1,2,0 order.
- bytes_avail=0, incnt=8, req Get 16 -> no grant until bytes_avail=1; req 4 served meanwhile; nbits=25 -> err, rd_data 0.
- rd_ptr at 2047 -> next fetch addr 0; with BSCTRL_ALIGN_EN, incnt=29 align -> incnt 24, align_done.
